uart_tx_arbiter: RTL and testbench

Shares the single UART transmit serializer (the one driving `uart_tx` at top level) between two byte sources: channel 0 (CPU output port) and channel 1 (debug/trace monitor). Each channel presents bytes on a valid/ready handshake with a `last` marker so that multi-byte messages are not interleaved. The block sequences each byte into the serializer (`tx_start` pulse, then wait for `tx_busy` to rise and fall) and enforces a fairness cap on message length.

---
 rtl/uart_tx_arbiter_if.sv | 18 +
 rtl/uart_tx_arbiter.sv | 58 +++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: two byte-source handshakes plus the serializer load/busy link
interface uart_tx_arbiter_if #(parameter int DATA_W = 8);
  logic s0_valid, s0_last, s0_ready;
  logic [DATA_W-1:0] s0_data;
  logic s1_valid, s1_last, s1_ready;
  logic [DATA_W-1:0] s1_data;
  logic tx_start, tx_busy;
  logic [DATA_W-1:0] tx_data;
  logic [1:0] grant;
  modport master (
    output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, tx_busy,
    input  s0_ready, s1_ready, tx_start, tx_data, grant
  );
  modport slave (
    input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, tx_busy,
    output s0_ready, s1_ready, tx_start, tx_data, grant
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART serializer between two byte channels with message lock and length cap
// Define UART_ARB_RR_EN for round-robin ties; otherwise channel 0 has fixed priority.
module uart_tx_arbiter #(
  parameter int DATA_W = 8,
  parameter int LOCK_MAX = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;
  localparam logic [7:0] CNT_LIM = 8'(LOCK_MAX - 1);
  state_t state, nxt;
  logic [DATA_W-1:0] data_q;
  logic [7:0] cnt;
  logic owner, locked, sel, sel_valid, sel_last, acc, tie, hold;
`ifdef UART_ARB_RR_EN
  logic last_ch;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_ch <= 1'b1;
    else if (acc) last_ch <= sel;
  assign tie = ~last_ch;
`else
  assign tie = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    sel = locked ? owner : (bus.s0_valid && bus.s1_valid) ? tie : bus.s1_valid;
    sel_valid = sel ? bus.s1_valid : bus.s0_valid;
    sel_last = sel ? bus.s1_last : bus.s0_last;
    acc = !rst && state == IDLE && sel_valid;
    nxt = state == IDLE ? (acc ? START : IDLE) :
          state == START ? WAIT_ACK :
          bus.tx_busy ? WAIT_DONE :
          state == WAIT_ACK ? WAIT_ACK : IDLE;
    hold = !sel_last && cnt < CNT_LIM;
    bus.s0_ready = acc && !sel;
    bus.s1_ready = acc && sel;
    bus.tx_start = state == START;
    bus.tx_data = data_q;
    bus.grant = (state != IDLE || locked) ? {owner, !owner} : 2'b00;
  end
  // hold: this byte keeps the channel locked; otherwise the message (or its cap) ends here
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q <= '0;
      owner <= 1'b0;
      locked <= 1'b0;
      cnt <= 8'd0;
    end else if (acc) begin
      data_q <= sel ? bus.s1_data : bus.s0_data;
      owner <= sel;
      locked <= hold;
      cnt <= hold ? cnt + 8'd1 : 8'd0;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: transaction-order model plus per-cycle handshake/serializer checks
module tb_uart_tx_arbiter;
  localparam int LOCK_MAX = 4;
  localparam int HOLD = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_auto = 1'b0;
  logic ser_busy = 1'b0;
  logic man_busy = 1'b0;
  int rise_cnt = 0;
  int hold_cnt = 0;
  int vecs = 0;
  int errs = 0;
  logic [8:0] q0[$], q1[$];
  logic [8:0] exp[$];
  logic m_lock, m_owner, m_last;
  int m_cnt;

  uart_tx_arbiter_if #(.DATA_W(8)) b ();
  uart_tx_arbiter #(.DATA_W(8), .LOCK_MAX(LOCK_MAX)) dut (.clk(clk), .rst(rst), .bus(b));

  assign b.tx_busy = ser_busy | man_busy;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Order in which bytes must reach the serializer, given every queued byte is already presented.
  task automatic predict();
    logic [8:0] a0[$], a1[$];
    logic [8:0] it;
    logic ch;
    a0 = q0;
    a1 = q1;
    while (a0.size() != 0 || a1.size() != 0) begin
      if (m_lock) ch = m_owner;
      else if (a0.size() != 0 && a1.size() != 0) begin
`ifdef UART_ARB_RR_EN
        ch = !m_last;
`else
        ch = 1'b0;
`endif
      end else ch = a1.size() != 0;
      if (ch ? a1.size() == 0 : a0.size() == 0) break;
      it = ch ? a1.pop_front() : a0.pop_front();
      exp.push_back({ch, it[7:0]});
      if (!it[8] && m_cnt < LOCK_MAX - 1) begin
        m_lock = 1'b1;
        m_cnt++;
        m_owner = ch;
      end else begin
        m_lock = 1'b0;
        m_cnt = 0;
      end
      m_last = ch;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_outputs", {b.tx_start, b.tx_data, b.grant, b.s0_ready, b.s1_ready}, 0);
    q0.delete();
    q1.delete();
    exp.delete();
    m_lock = 1'b0;
    m_owner = 1'b0;
    m_last = 1'b1;
    m_cnt = 0;
    ser_auto = 1'b0;
    man_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ser_auto = 1'b1;
  endtask

  task automatic drain(input string nm);
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && exp.size() == 0 && !b.tx_busy &&
          rise_cnt == 0 && hold_cnt == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      vecs++;
      errs++;
      $display("FAIL %s_timeout: pending exp=%0d q0=%0d q1=%0d", nm, exp.size(), q0.size(), q1.size());
    end
  endtask

  // serializer: busy rises the cycle after tx_start and stays high HOLD cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (!ser_auto) begin
      rise_cnt = 0;
      hold_cnt = 0;
      ser_busy = 1'b0;
    end else if (rise_cnt > 0) begin
      rise_cnt = 0;
      ser_busy = 1'b1;
      hold_cnt = HOLD;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) ser_busy = 1'b0;
    end else if (b.tx_start) rise_cnt = 1;
  end

  // sources: present queue heads, pop on observed handshake
  initial begin : drv
    logic a0, a1;
    logic [8:0] tmp;
    {b.s0_valid, b.s0_last, b.s0_data} = '0;
    {b.s1_valid, b.s1_last, b.s1_data} = '0;
    forever begin
      @(negedge clk);
      a0 = b.s0_valid && b.s0_ready;
      a1 = b.s1_valid && b.s1_ready;
      @(posedge clk);
      #1;
      if (a0 && q0.size() != 0) tmp = q0.pop_front();
      if (a1 && q1.size() != 0) tmp = q1.pop_front();
      b.s0_valid = q0.size() != 0;
      {b.s0_last, b.s0_data} = q0.size() != 0 ? q0[0] : 9'h0;
      b.s1_valid = q1.size() != 0;
      {b.s1_last, b.s1_data} = q1.size() != 0 ? q1[0] : 9'h0;
    end
  end

  initial begin : cmp
    logic due, a0, a1;
    logic [8:0] e, got;
    due = 1'b0;
    e = '0;
    forever begin
      @(negedge clk);
      if (rst) due = 1'b0;
      else begin
        chk("tx_start", b.tx_start, due);
        if (due) begin
          chk("tx_data", b.tx_data, e[7:0]);
          chk("grant", b.grant, e[8] ? 2'b10 : 2'b01);
        end
        due = 1'b0;
        chk("single_ready", b.s0_ready & b.s1_ready, 0);
        a0 = b.s0_valid && b.s0_ready;
        a1 = b.s1_valid && b.s1_ready;
        got = {a1, a1 ? b.s1_data : b.s0_data};
        if (a0 || a1) begin
          if (exp.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_accept: got ch%0d byte %0h, none required", got[8], got[7:0]);
          end else begin
            e = exp.pop_front();
            chk("accept_order", got, e);
            due = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int nr, ns;
    do_reset();
    // single byte from s0
    @(negedge clk);
    q0.push_back({1'b1, 8'h41});
    predict();
    chk("t1_model", exp[0], {1'b0, 8'h41});
    nr = 0;
    ns = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      nr += int'(b.s0_ready);
      ns += int'(b.tx_start);
    end
    chk("t1_ready_cycles", nr, 1);
    chk("t1_start_pulses", ns, 1);
    drain("t1");
    chk("t1_grant_idle", b.grant, 2'b00);
    chk("t1_tx_data_held", b.tx_data, 8'h41);
    // s0 message vs waiting s1
    do_reset();
    @(negedge clk);
    q0.push_back({1'b0, 8'h48});
    q0.push_back({1'b0, 8'h49});
    q0.push_back({1'b1, 8'h0A});
    q1.push_back({1'b1, 8'h55});
    predict();
    chk("t2_model_size", exp.size(), 4);
    chk("t2_model2", exp[2], {1'b0, 8'h0A});
    chk("t2_model3", exp[3], {1'b1, 8'h55});
    drain("t2");
    // length cap on an s1 run
    do_reset();
    @(negedge clk);
    q1.push_back({1'b0, 8'h11});
    predict();
    for (int i = 0; i < 50 && q1.size() != 0; i++) @(negedge clk);
    chk("t3_first_taken", q1.size(), 0);
    for (int i = 2; i <= 6; i++) q1.push_back({1'b0, 8'(8'h10 + i)});
    q0.push_back({1'b1, 8'h30});
    predict();
    chk("t3_model2", exp[2], {1'b1, 8'h14});
    chk("t3_model3", exp[3], {1'b0, 8'h30});
    chk("t3_model4", exp[4], {1'b1, 8'h15});
    drain("t3");
    // continuous tie with single-byte messages
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b1, 8'(8'hA0 + i)});
      q1.push_back({1'b1, 8'(8'hB0 + i)});
    end
    predict();
    chk("t4_model0", exp[0], {1'b0, 8'hA0});
`ifdef UART_ARB_RR_EN
    chk("t4_model1", exp[1], {1'b1, 8'hB0});
    chk("t4_model2", exp[2], {1'b0, 8'hA1});
`else
    chk("t4_model1", exp[1], {1'b0, 8'hA1});
    chk("t4_model3", exp[3], {1'b1, 8'hB0});
`endif
    drain("t4");
    // reset while locked in WAIT_DONE
    do_reset();
    @(negedge clk);
    q0.push_back({1'b0, 8'h60});
    predict();
    for (int i = 0; i < 20 && !b.tx_busy; i++) @(negedge clk);
    chk("t5_busy_seen", b.tx_busy, 1);
    repeat (2) @(negedge clk);
    chk("t5_grant_locked", b.grant, 2'b01);
    do_reset();
    @(negedge clk);
    q1.push_back({1'b1, 8'h77});
    predict();
    @(negedge clk);
    chk("t5_s1_ready_now", b.s1_ready, 1);
    drain("t5");
    // busy already high at START
    do_reset();
    ser_auto = 1'b0;
    man_busy = 1'b1;
    @(negedge clk);
    q0.push_back({1'b1, 8'h5A});
    q1.push_back({1'b1, 8'h5B});
    predict();
    nr = 0;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nr += int'(b.s0_ready) + int'(b.s1_ready);
      ns += int'(b.tx_start);
    end
    chk("t6_ready_cycles", nr, 1);
    chk("t6_start_pulses", ns, 1);
    chk("t6_data_first", b.tx_data, 8'h5A);
    man_busy = 1'b0;
    ser_auto = 1'b1;
    drain("t6");
    chk("t6_data_second", b.tx_data, 8'h5B);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
